// File: rtl/bfm_ahbl2apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB (PM side) bridge.
// Optional ACCESS watchdog is enabled by defining BFM_AHBL2APB_TIMEOUT_EN.
package bfm_ahbl2apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DPHASE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Largest supported HSIZE (word); anything wider is answered with ERROR.
    localparam logic [2:0] HSIZE_MAX = 3'd2;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/bfm_ahbl2apb_wdog.sv
// ACCESS-phase watchdog: counts ACCESS cycles and flags expiry at TIMEOUT-1.
// Only instantiated when BFM_AHBL2APB_TIMEOUT_EN is defined.
module bfm_ahbl2apb_wdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [15:0] cnt_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && !expired) begin
            cnt_reg <= cnt_reg + 16'd1;
        end
    end

    assign expired = en && (cnt_reg == 16'(TIMEOUT - 1));

endmodule

// File: rtl/bfm_ahbl2apb_pm.sv
// AHB-Lite slave to single-channel APB master, driving the PM port of the APB clock-domain bridge.
// Define BFM_AHBL2APB_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles with an ERROR response.
module bfm_ahbl2apb_pm
    import bfm_ahbl2apb_pkg::*;
#(
    parameter int TPD     = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic        PCLK_PM,
    input  logic        PRESETN_PM,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] PADDR_PM,
    output logic        PWRITE_PM,
    output logic        PENABLE_PM,
    output logic [31:0] PWDATA_PM,
    input  logic [31:0] PRDATA_PM,
    input  logic        PREADY_PM,
    input  logic        PSLVERR_PM
);

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] paddr_reg;
    logic [31:0] pwdata_reg;
    logic [31:0] hrdata_reg;
    logic        pwrite_reg;
    logic        accept;
    logic        size_err;
    logic        access_done;
    logic        timeout_hit;

    // TPD only models output delay in behavioural sims; this model is zero-delay.
    generate
        if (TPD < 0 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_out_of_range
        end
    endgenerate

    assign accept      = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    assign size_err    = (HSIZE > HSIZE_MAX);
    assign access_done = (state_reg == ST_ACCESS) && PREADY_PM;

`ifdef BFM_AHBL2APB_TIMEOUT_EN
    bfm_ahbl2apb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (PCLK_PM),
        .rstn    (PRESETN_PM),
        .clr     (state_reg == ST_SETUP),
        .en      (state_reg == ST_ACCESS),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    state_next = size_err ? ST_ERR1 : ST_DPHASE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_DPHASE: state_next = ST_SETUP;
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: begin
                // A completion on the expiry cycle wins over the timeout.
                if (PREADY_PM) begin
                    state_next = PSLVERR_PM ? ST_ERR1 : ST_RESP;
                end else if (timeout_hit) begin
                    state_next = ST_ERR1;
                end
            end
            ST_ERR1:   state_next = ST_ERR2;
            ST_ERR2:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
        if (!PRESETN_PM) begin
            state_reg  <= ST_IDLE;
            paddr_reg  <= '0;
            pwrite_reg <= 1'b0;
            pwdata_reg <= '0;
            hrdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_next == ST_IDLE) begin
                paddr_reg  <= '0;
                pwrite_reg <= 1'b0;
                pwdata_reg <= '0;
            end else if (state_next == ST_DPHASE) begin
                paddr_reg  <= HADDR;
                pwrite_reg <= HWRITE;
            end
            if (state_reg == ST_DPHASE) begin
                pwdata_reg <= pwrite_reg ? HWDATA : '0;
            end
            if (access_done && !pwrite_reg) begin
                hrdata_reg <= PRDATA_PM;
            end else if ((state_reg == ST_ACCESS) && timeout_hit) begin
                hrdata_reg <= TIMEOUT_RDATA;
            end
        end
    end

    assign HREADYOUT  = (state_reg == ST_IDLE) || (state_reg == ST_RESP) || (state_reg == ST_ERR2);
    assign HRESP      = ((state_reg == ST_ERR1) || (state_reg == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA     = hrdata_reg;
    assign PADDR_PM   = paddr_reg;
    assign PWRITE_PM  = pwrite_reg;
    assign PENABLE_PM = (state_reg == ST_ACCESS);
    assign PWDATA_PM  = pwdata_reg;

endmodule

// File: tb/tb_bfm_ahbl2apb_pm.sv
// Directed self-checking bench for bfm_ahbl2apb_pm; the timeout case runs only
// when BFM_AHBL2APB_TIMEOUT_EN is defined.
module tb_bfm_ahbl2apb_pm;

    logic        PCLK_PM;
    logic        PRESETN_PM;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] PADDR_PM;
    logic        PWRITE_PM;
    logic        PENABLE_PM;
    logic [31:0] PWDATA_PM;
    logic [31:0] PRDATA_PM;
    logic        PREADY_PM;
    logic        PSLVERR_PM;

    int n_checks = 0;
    int n_errors = 0;

    // APB responder configuration and monitor state
    int          rsp_waits = 0;
    logic        rsp_err = 1'b0;
    logic        rsp_hang = 1'b0;
    logic [31:0] rsp_rdata = '0;
    logic        pready_resp = 1'b0;
    logic        pready_manual = 1'b0;
    logic        pen_prev = 1'b0;
    int          pen_rises = 0;
    int          acc_cnt = 0;
    int          acc_unstable = 0;
    int          gap = 0;
    int          gap_busy = 0;
    int          last_gap = 0;
    int          last_gap_busy = 0;
    logic [31:0] cap_paddr = '0;
    logic [31:0] cap_pwdata = '0;
    logic        cap_pwrite = 1'b0;

    logic [31:0] r_data;
    logic        r_resp;
    logic        r_prev;
    int          r_lo;
    int          rises_before;

    assign HREADY    = HREADYOUT;
    assign PREADY_PM = pready_resp | pready_manual;

    bfm_ahbl2apb_pm #(
        .TPD     (1),
        .TIMEOUT (8)
    ) dut (
        .PCLK_PM    (PCLK_PM),
        .PRESETN_PM (PRESETN_PM),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HWRITE     (HWRITE),
        .HTRANS     (HTRANS),
        .HSIZE      (HSIZE),
        .HREADY     (HREADY),
        .HWDATA     (HWDATA),
        .HRDATA     (HRDATA),
        .HREADYOUT  (HREADYOUT),
        .HRESP      (HRESP),
        .PADDR_PM   (PADDR_PM),
        .PWRITE_PM  (PWRITE_PM),
        .PENABLE_PM (PENABLE_PM),
        .PWDATA_PM  (PWDATA_PM),
        .PRDATA_PM  (PRDATA_PM),
        .PREADY_PM  (PREADY_PM),
        .PSLVERR_PM (PSLVERR_PM)
    );

    initial PCLK_PM = 1'b0;
    always #5 PCLK_PM = ~PCLK_PM;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Responder drives PREADY in ACCESS cycle rsp_waits+1; monitor tracks PENABLE gaps and stability.
    always @(negedge PCLK_PM) begin
        PRDATA_PM = rsp_rdata;
        if (PENABLE_PM) begin
            if (!pen_prev) begin
                pen_rises++;
                last_gap      = gap;
                last_gap_busy = gap_busy;
                acc_cnt       = 0;
                cap_paddr     = PADDR_PM;
                cap_pwdata    = PWDATA_PM;
                cap_pwrite    = PWRITE_PM;
            end else if (PADDR_PM !== cap_paddr || PWDATA_PM !== cap_pwdata || PWRITE_PM !== cap_pwrite) begin
                acc_unstable++;
            end
            acc_cnt++;
            if (!rsp_hang && acc_cnt == rsp_waits + 1) begin
                pready_resp = 1'b1;
                PSLVERR_PM  = rsp_err;
            end else begin
                pready_resp = 1'b0;
                PSLVERR_PM  = 1'b0;
            end
        end else begin
            if (pen_prev) begin
                gap      = 0;
                gap_busy = 0;
            end
            gap++;
            if (!HREADYOUT) gap_busy++;
            pready_resp = 1'b0;
            PSLVERR_PM  = 1'b0;
        end
        pen_prev = PENABLE_PM;
    end

    task automatic addr_drive(input logic sel, input logic [1:0] trans, input logic wr,
                              input logic [31:0] addr, input logic [2:0] size);
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = wr;
        HADDR  = addr;
        HSIZE  = size;
    endtask

    // Runs one AHB data phase; returns at #1 after the edge that ends it.
    task automatic data_phase(input logic [31:0] wdata, output logic [31:0] rdata,
                              output logic resp, output logic resp_prev, output int lo);
        HWDATA    = wdata;
        lo        = 0;
        resp_prev = 1'b0;
        rdata     = 'x;
        resp      = 1'bx;
        for (int i = 0; i < 200; i++) begin
            @(negedge PCLK_PM);
            if (HREADYOUT) begin
                rdata = HRDATA;
                resp  = HRESP;
                @(posedge PCLK_PM);
                #1;
                return;
            end
            lo++;
            resp_prev = HRESP;
        end
        check("dphase_bound", {31'b0, HREADYOUT}, 32'd1);
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] size, input int waits, input logic err, input logic [31:0] prdata,
                        output logic [31:0] rdata, output logic resp, output logic resp_prev, output int lo);
        rsp_waits = waits;
        rsp_err   = err;
        rsp_rdata = prdata;
        addr_drive(1'b1, 2'b10, wr, addr, size);
        @(posedge PCLK_PM);
        #1;
        addr_drive(1'b0, 2'b00, 1'b0, 32'h0, 3'd0);
        data_phase(wdata, rdata, resp, resp_prev, lo);
        $display("txn %s addr=%h size=%0d wdata=%h -> lo=%0d hresp=%0b hrdata=%h",
                 wr ? "WR" : "RD", addr, size, wdata, lo, resp, rdata);
    endtask

    initial begin
        PRESETN_PM    = 1'b0;
        HWDATA        = '0;
        PSLVERR_PM    = 1'b0;
        PRDATA_PM     = '0;
        addr_drive(1'b0, 2'b00, 1'b0, 32'h0, 3'd0);
        repeat (2) @(negedge PCLK_PM);
        check("rst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
        check("rst_hresp",     {31'b0, HRESP}, 32'd0);
        check("rst_hrdata",    HRDATA, 32'h0);
        check("rst_paddr",     PADDR_PM, 32'h0);
        check("rst_pwrite",    {31'b0, PWRITE_PM}, 32'd0);
        check("rst_penable",   {31'b0, PENABLE_PM}, 32'd0);
        check("rst_pwdata",    PWDATA_PM, 32'h0);
        @(posedge PCLK_PM);
        #1;
        PRESETN_PM = 1'b1;
        @(posedge PCLK_PM);
        #1;

        // Write with PREADY in the fourth ACCESS cycle
        acc_unstable = 0;
        xfer(1'b1, 32'h0300_0010, 32'hA5A5_1234, 3'd2, 3, 1'b0, 32'h0, r_data, r_resp, r_prev, r_lo);
        check("wr_low_cycles", r_lo, 32'd6);
        check("wr_hresp",      {31'b0, r_resp}, 32'd0);
        check("wr_paddr",      cap_paddr, 32'h0300_0010);
        check("wr_pwdata",     cap_pwdata, 32'hA5A5_1234);
        check("wr_pwrite",     {31'b0, cap_pwrite}, 32'd1);
        check("wr_stable",     acc_unstable, 32'd0);
        check("wr_acc_cycles", acc_cnt, 32'd4);

        // Zero-wait read
        xfer(1'b0, 32'h0500_0004, 32'h0, 3'd2, 0, 1'b0, 32'h1234_5678, r_data, r_resp, r_prev, r_lo);
        check("rd_low_cycles", r_lo, 32'd3);
        check("rd_hrdata",     r_data, 32'h1234_5678);
        check("rd_hresp",      {31'b0, r_resp}, 32'd0);
        check("rd_paddr",      cap_paddr, 32'h0500_0004);
        check("rd_pwrite",     {31'b0, cap_pwrite}, 32'd0);
        check("rd_pwdata",     cap_pwdata, 32'h0);
        check("idle_paddr",    PADDR_PM, 32'h0);

        // Stray PREADY while IDLE must not disturb HRDATA or state
        rsp_rdata     = 32'h5555_AAAA;
        pready_manual = 1'b1;
        @(posedge PCLK_PM);
        #1;
        pready_manual = 1'b0;
        @(negedge PCLK_PM);
        check("late_hrdata",    HRDATA, 32'h1234_5678);
        check("late_hreadyout", {31'b0, HREADYOUT}, 32'd1);
        check("late_penable",   {31'b0, PENABLE_PM}, 32'd0);
        @(posedge PCLK_PM);
        #1;

        // Back-to-back NONSEQ write then read
        rsp_waits = 0;
        rsp_err   = 1'b0;
        addr_drive(1'b1, 2'b10, 1'b1, 32'h0300_0020, 3'd2);
        @(posedge PCLK_PM);
        #1;
        addr_drive(1'b1, 2'b10, 1'b0, 32'h0300_0024, 3'd2);
        data_phase(32'h1111_2222, r_data, r_resp, r_prev, r_lo);
        $display("txn WR addr=03000020 b2b -> lo=%0d hresp=%0b", r_lo, r_resp);
        check("b2b_wr_low",   r_lo, 32'd3);
        check("b2b_wr_hresp", {31'b0, r_resp}, 32'd0);
        addr_drive(1'b0, 2'b00, 1'b0, 32'h0, 3'd0);
        rsp_waits = 1;
        rsp_rdata = 32'hCAFE_F00D;
        data_phase(32'h0, r_data, r_resp, r_prev, r_lo);
        $display("txn RD addr=03000024 b2b -> lo=%0d hresp=%0b hrdata=%h", r_lo, r_resp, r_data);
        check("b2b_rd_low",     r_lo, 32'd4);
        check("b2b_rd_hresp",   {31'b0, r_resp}, 32'd0);
        check("b2b_rd_hrdata",  r_data, 32'hCAFE_F00D);
        check("b2b_rd_paddr",   cap_paddr, 32'h0300_0024);
        check("b2b_pen_low",    last_gap_busy, 32'd2);
        check("b2b_pen_low_ge2", {31'b0, (last_gap >= 2)}, 32'd1);

        // Slave error
        xfer(1'b1, 32'h0300_0030, 32'hDEAD_0001, 3'd2, 0, 1'b1, 32'h0, r_data, r_resp, r_prev, r_lo);
        check("err_low_cycles", r_lo, 32'd4);
        check("err_hresp_1st",  {31'b0, r_prev}, 32'd1);
        check("err_hresp_2nd",  {31'b0, r_resp}, 32'd1);
        addr_drive(1'b1, 2'b00, 1'b0, 32'h0300_0034, 3'd2);
        @(negedge PCLK_PM);
        check("err_idle_ready", {31'b0, HREADYOUT}, 32'd1);
        check("err_idle_hresp", {31'b0, HRESP}, 32'd0);
        @(posedge PCLK_PM);
        #1;
        addr_drive(1'b0, 2'b00, 1'b0, 32'h0, 3'd0);

        // Oversized transfer: ERROR without APB activity
        rises_before = pen_rises;
        xfer(1'b1, 32'h0300_0040, 32'h7777_7777, 3'b011, 0, 1'b0, 32'h0, r_data, r_resp, r_prev, r_lo);
        check("hsize_low_cycles", r_lo, 32'd1);
        check("hsize_hresp_1st",  {31'b0, r_prev}, 32'd1);
        check("hsize_hresp_2nd",  {31'b0, r_resp}, 32'd1);
        check("hsize_no_apb",     pen_rises, rises_before);

        // BUSY: zero-wait OKAY, no APB access
        addr_drive(1'b1, 2'b01, 1'b1, 32'h0300_0050, 3'd2);
        $display("txn BUSY addr=03000050");
        repeat (2) begin
            @(negedge PCLK_PM);
            check("busy_hreadyout", {31'b0, HREADYOUT}, 32'd1);
            check("busy_hresp",     {31'b0, HRESP}, 32'd0);
            @(posedge PCLK_PM);
            #1;
        end
        addr_drive(1'b0, 2'b00, 1'b0, 32'h0, 3'd0);
        @(negedge PCLK_PM);
        check("busy_no_apb", pen_rises, rises_before);
        @(posedge PCLK_PM);
        #1;

`ifdef BFM_AHBL2APB_TIMEOUT_EN
        rsp_hang = 1'b1;
        xfer(1'b0, 32'h0500_0008, 32'h0, 3'd2, 0, 1'b0, 32'h0, r_data, r_resp, r_prev, r_lo);
        rsp_hang = 1'b0;
        check("to_low_cycles", r_lo, 32'd11);
        check("to_acc_cycles", acc_cnt, 32'd8);
        check("to_hrdata",     r_data, 32'hDEAD_BEEF);
        check("to_hresp",      {31'b0, r_resp}, 32'd1);
        rsp_rdata     = 32'h0BAD_0BAD;
        pready_manual = 1'b1;
        @(posedge PCLK_PM);
        #1;
        pready_manual = 1'b0;
        @(negedge PCLK_PM);
        check("to_late_hrdata",  HRDATA, 32'hDEAD_BEEF);
        check("to_late_ready",   {31'b0, HREADYOUT}, 32'd1);
        check("to_late_penable", {31'b0, PENABLE_PM}, 32'd0);
        @(posedge PCLK_PM);
        #1;
`endif

        // Asynchronous reset in the middle of ACCESS
        rsp_hang = 1'b1;
        addr_drive(1'b1, 2'b10, 1'b0, 32'h0500_000C, 3'd2);
        @(posedge PCLK_PM);
        #1;
        addr_drive(1'b0, 2'b00, 1'b0, 32'h0, 3'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge PCLK_PM);
            if (PENABLE_PM) break;
        end
        check("rst_access_reached", {31'b0, PENABLE_PM}, 32'd1);
        #1;
        PRESETN_PM = 1'b0;
        #1;
        $display("txn RESET during ACCESS addr=0500000c");
        check("arst_penable",   {31'b0, PENABLE_PM}, 32'd0);
        check("arst_paddr",     PADDR_PM, 32'h0);
        check("arst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
        rsp_hang = 1'b0;
        @(posedge PCLK_PM);
        #1;
        PRESETN_PM = 1'b1;
        repeat (2) @(posedge PCLK_PM);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
